// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over a multi-cycle unit,
// with a pending-destination scoreboard and starvation hold. Optional stats: RF_WB_ARB_STATS_EN.
module rf_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we_i,
  input  logic [4:0]        pipe_rd_i,
  input  logic [DATA_W-1:0] pipe_data_i,
  input  logic              mc_issue_i,
  input  logic [4:0]        mc_issue_rd_i,
  input  logic              mc_valid_i,
  input  logic [4:0]        mc_rd_i,
  input  logic [DATA_W-1:0] mc_data_i,
  output logic              mc_ready_o,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  output logic              hazard_o,
  output logic              pipe_hold_o,
  output logic              RegWrite_o,
  output logic [4:0]        RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o
`ifdef RF_WB_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt_o,
  output logic [15:0]       hold_cnt_o
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [3:0] LIMIT_W = 4'(STARVE_LIMIT);

  logic         pipe_act;
  logic         mc_xfer;
  logic         mc_blocked;
  logic [31:1]  pending_reg;
  logic [31:1]  pending_next;
  logic [31:0]  pending_vec;
  state_t       state_reg;
  logic [3:0]   wait_cnt_reg;
  logic         hold_reg;

  assign pipe_act   = pipe_we_i & (pipe_rd_i != 5'd0);
  assign mc_ready_o = rst_n & ~pipe_act;
  assign mc_xfer    = mc_valid_i & mc_ready_o;
  assign mc_blocked = mc_valid_i & ~mc_ready_o;

  always_comb begin
    RegWrite_o = 1'b0;
    RDaddr_o   = 5'd0;
    RDdata_o   = '0;
    if (rst_n) begin
      if (pipe_act) begin
        RegWrite_o = 1'b1;
        RDaddr_o   = pipe_rd_i;
        RDdata_o   = pipe_data_i;
      end else if (mc_xfer) begin
        // An MC result aimed at x0 still retires the handshake, just without a write.
        RegWrite_o = (mc_rd_i != 5'd0);
        RDaddr_o   = mc_rd_i;
        RDdata_o   = mc_data_i;
      end
    end
  end

  // Per-register next state; a same-cycle issue overrides the completing clear.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_pending
      logic set_bit;
      logic clr_bit;
      assign set_bit          = mc_issue_i & (mc_issue_rd_i == 5'(gi));
      assign clr_bit          = mc_xfer & (mc_rd_i == 5'(gi));
      assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign pending_vec = {pending_reg, 1'b0};
  assign hazard_o    = rst_n & (pending_vec[rs_addr_i] | pending_vec[rt_addr_i]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 4'd0;
      hold_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mc_blocked) begin
            if (wait_cnt_reg + 4'd1 >= LIMIT_W) begin
              state_reg    <= ST_HOLD;
              hold_reg     <= 1'b1;
              wait_cnt_reg <= LIMIT_W;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 4'd1;
            end
          end else begin
            wait_cnt_reg <= 4'd0;
          end
        end
        ST_HOLD: begin
          // Pipeline writes may keep arriving; only a real transfer releases the hold.
          if (mc_xfer) begin
            state_reg    <= ST_IDLE;
            hold_reg     <= 1'b0;
            wait_cnt_reg <= 4'd0;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          hold_reg     <= 1'b0;
          wait_cnt_reg <= 4'd0;
        end
      endcase
    end
  end

  assign pipe_hold_o = hold_reg;

`ifdef RF_WB_ARB_STATS_EN
  logic [15:0] conflict_cnt_reg;
  logic [15:0] hold_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt_reg <= 16'd0;
      hold_cnt_reg     <= 16'd0;
    end else begin
      if (mc_valid_i && pipe_act && (conflict_cnt_reg != 16'hFFFF)) begin
        conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
      end
      if (hold_reg && (hold_cnt_reg != 16'hFFFF)) begin
        hold_cnt_reg <= hold_cnt_reg + 16'd1;
      end
    end
  end

  assign conflict_cnt_o = conflict_cnt_reg;
  assign hold_cnt_o     = hold_cnt_reg;
`endif

`ifndef SYNTHESIS
  // Re-issuing to a pending register is an upstream bug unless that register retires this cycle.
  a_no_double_issue : assert property (@(posedge clk) disable iff (!rst_n)
    !(mc_issue_i && (mc_issue_rd_i != 5'd0) && pending_vec[mc_issue_rd_i] &&
      !(mc_xfer && (mc_rd_i == mc_issue_rd_i))));
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of port priority, scoreboard and starvation.
module tb_rf_wb_arbiter;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_we;
  logic [4:0]    pipe_rd;
  logic [DW-1:0] pipe_data;
  logic          mc_issue;
  logic [4:0]    mc_issue_rd;
  logic          mc_valid;
  logic [4:0]    mc_rd;
  logic [DW-1:0] mc_data;
  logic          mc_ready;
  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic          hazard;
  logic          pipe_hold;
  logic          reg_write;
  logic [4:0]    rd_addr;
  logic [DW-1:0] rd_data;
`ifdef RF_WB_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
  logic [15:0]   hold_cnt;
`endif

  rf_wb_arbiter #(.DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
    .mc_issue_i(mc_issue), .mc_issue_rd_i(mc_issue_rd),
    .mc_valid_i(mc_valid), .mc_rd_i(mc_rd), .mc_data_i(mc_data),
    .mc_ready_o(mc_ready),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .hazard_o(hazard), .pipe_hold_o(pipe_hold),
    .RegWrite_o(reg_write), .RDaddr_o(rd_addr), .RDdata_o(rd_data)
`ifdef RF_WB_ARB_STATS_EN
    , .conflict_cnt_o(conflict_cnt), .hold_cnt_o(hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit pend[32];
  int m_blocked;
  bit m_hold;
  int m_conf;
  int m_holdc;

  function automatic bit m_act();
    return pipe_we && (pipe_rd != 5'd0);
  endfunction
  function automatic bit exp_ready();
    return rst_n && !m_act();
  endfunction
  function automatic bit m_xfer();
    return mc_valid && exp_ready();
  endfunction
  function automatic bit exp_we();
    return rst_n && (m_act() || (m_xfer() && mc_rd != 5'd0));
  endfunction
  function automatic logic [4:0] exp_addr();
    if (!rst_n) return 5'd0;
    if (m_act()) return pipe_rd;
    if (m_xfer()) return mc_rd;
    return 5'd0;
  endfunction
  function automatic logic [DW-1:0] exp_data();
    if (!rst_n) return '0;
    if (m_act()) return pipe_data;
    if (m_xfer()) return mc_data;
    return '0;
  endfunction
  function automatic bit exp_hazard();
    return rst_n && (pend[rs_addr] || pend[rt_addr]);
  endfunction

  task automatic set_idle();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    mc_issue = 0; mc_issue_rd = 0;
    mc_valid = 0; mc_rd = 0; mc_data = 0;
    rs_addr = 0; rt_addr = 0;
  endtask

  // Advance one clock and apply the specification's state rules to the model.
  task automatic tick();
    bit act, rdy, xfer;
    act  = m_act();
    rdy  = exp_ready();
    xfer = m_xfer();
    @(posedge clk);
    if (!rst_n) begin
      foreach (pend[i]) pend[i] = 0;
      m_blocked = 0; m_hold = 0; m_conf = 0; m_holdc = 0;
    end else begin
      if (mc_valid && act && m_conf < 65535) m_conf++;
      if (m_hold && m_holdc < 65535) m_holdc++;
      if (xfer) pend[mc_rd] = 0;
      if (mc_issue && mc_issue_rd != 0) pend[mc_issue_rd] = 1;
      if (m_hold) begin
        if (xfer) begin m_hold = 0; m_blocked = 0; end
      end else if (mc_valid && !rdy) begin
        m_blocked++;
        if (m_blocked >= LIMIT) m_hold = 1;
      end else begin
        m_blocked = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    $display("test_reset");
    set_idle();
    rst_n = 0; pipe_we = 1; pipe_rd = 5; pipe_data = 32'h55; mc_valid = 1; mc_rd = 3;
    #2;
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", reg_write); end
    total++; if (mc_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", mc_ready); end
    total++; if (rd_addr !== 5'd0 || rd_data !== '0) begin bad++; $display("FAIL reset_addr_data got=%0d/%h want=0/0", rd_addr, rd_data); end
    tick();
    set_idle();
    #2;
    total++; if (pipe_hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%0b want=0", pipe_hold); end
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%0b want=0", hazard); end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_priority();
    $display("test_priority");
    set_idle();
    pipe_we = 1; pipe_rd = 5; pipe_data = 32'h1234;
    mc_valid = 1; mc_rd = 7; mc_data = 32'hABCD;
    #2;
    total++; if (reg_write !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'h1234) begin
      bad++; $display("FAIL prio_pipe got=%0b/%0d/%h want=1/5/1234", reg_write, rd_addr, rd_data); end
    total++; if (mc_ready !== 1'b0) begin bad++; $display("FAIL prio_ready got=%0b want=0", mc_ready); end
    tick();
    pipe_we = 0;
    #2;
    total++; if (reg_write !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'hABCD || mc_ready !== 1'b1) begin
      bad++; $display("FAIL prio_mc got=%0b/%0d/%h/%0b want=1/7/abcd/1", reg_write, rd_addr, rd_data, mc_ready); end
    tick();
    set_idle();
    #2;
    total++; if (reg_write !== 1'b0 || rd_addr !== 5'd0 || rd_data !== '0) begin
      bad++; $display("FAIL idle_port got=%0b/%0d/%h want=0/0/0", reg_write, rd_addr, rd_data); end
    tick();
  endtask

  task automatic test_x0_drop();
    $display("test_x0_drop");
    set_idle();
    pipe_we = 1; pipe_rd = 0; pipe_data = 32'hDEAD;
    mc_valid = 1; mc_rd = 3; mc_data = 32'h3333;
    #2;
    total++; if (mc_ready !== 1'b1 || reg_write !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h3333) begin
      bad++; $display("FAIL x0_drop got=%0b/%0b/%0d/%h want=1/1/3/3333", mc_ready, reg_write, rd_addr, rd_data); end
    tick();
    pipe_we = 0; mc_rd = 0; mc_data = 32'h77;
    #2;
    total++; if (mc_ready !== 1'b1 || reg_write !== 1'b0) begin
      bad++; $display("FAIL mc_x0 got=%0b/%0b want=1/0", mc_ready, reg_write); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_scoreboard();
    $display("test_scoreboard");
    set_idle();
    mc_issue = 1; mc_issue_rd = 9; rs_addr = 9; rt_addr = 1;
    #2;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL sb_before got=%0b want=0", hazard); end
    tick();
    mc_issue = 0;
    #2;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL sb_set got=%0b want=1", hazard); end
    rs_addr = 2; rt_addr = 9;
    #1;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL sb_rt got=%0b want=1", hazard); end
    tick();
    mc_valid = 1; mc_rd = 9; mc_data = 32'h9999;
    #2;
    total++; if (reg_write !== 1'b1 || rd_addr !== 5'd9 || hazard !== 1'b1) begin
      bad++; $display("FAIL sb_write got=%0b/%0d/%0b want=1/9/1", reg_write, rd_addr, hazard); end
    tick();
    mc_valid = 0;
    #2;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL sb_clear got=%0b want=0", hazard); end
    tick();
  endtask

  task automatic test_starvation();
    $display("test_starvation");
    set_idle();
    mc_valid = 1; mc_rd = 4; mc_data = 32'h4444;
    for (int k = 0; k < LIMIT - 1; k++) begin
      pipe_we = 1; pipe_rd = 5'($urandom_range(1, 31)); pipe_data = $urandom;
      tick();
    end
    mc_valid = 0;
    tick();
    mc_valid = 1;
    for (int k = 0; k < LIMIT + 2; k++) begin
      pipe_we = 1; pipe_rd = 5'($urandom_range(1, 31)); pipe_data = $urandom;
      #2;
      total++; if (pipe_hold !== (k >= LIMIT) || mc_ready !== 1'b0) begin
        bad++; $display("FAIL starve_k%0d got=%0b/%0b want=%0b/0", k, pipe_hold, mc_ready, (k >= LIMIT)); end
      tick();
    end
    pipe_we = 0;
    #2;
    total++; if (mc_ready !== 1'b1 || reg_write !== 1'b1 || rd_addr !== 5'd4 || pipe_hold !== 1'b1) begin
      bad++; $display("FAIL starve_xfer got=%0b/%0b/%0d/%0b want=1/1/4/1", mc_ready, reg_write, rd_addr, pipe_hold); end
    tick();
    mc_valid = 0;
    #2;
    total++; if (pipe_hold !== 1'b0) begin bad++; $display("FAIL starve_exit got=%0b want=0", pipe_hold); end
    tick();
  endtask

  task automatic test_set_clear_reset();
    $display("test_set_clear_reset");
    set_idle();
    rs_addr = 12;
    mc_issue = 1; mc_issue_rd = 12;
    tick();
    mc_valid = 1; mc_rd = 12; mc_data = 32'hC0C0;
    #2;
    total++; if (reg_write !== 1'b1 || rd_addr !== 5'd12 || hazard !== 1'b1) begin
      bad++; $display("FAIL setclr_write got=%0b/%0d/%0b want=1/12/1", reg_write, rd_addr, hazard); end
    tick();
    mc_issue = 0; mc_valid = 0;
    #2;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL setclr_wins got=%0b want=1", hazard); end
    rst_n = 0; pipe_we = 1; pipe_rd = 6; pipe_data = 32'h66;
    #1;
    total++; if (reg_write !== 1'b0 || mc_ready !== 1'b0) begin
      bad++; $display("FAIL midreset_we got=%0b/%0b want=0/0", reg_write, mc_ready); end
    tick();
    rst_n = 1; pipe_we = 0;
    #2;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL midreset_pend got=%0b want=0", hazard); end
    mc_valid = 1; mc_rd = 12; mc_data = 32'h1212;
    #1;
    total++; if (reg_write !== 1'b1 || rd_addr !== 5'd12 || mc_ready !== 1'b1) begin
      bad++; $display("FAIL late_result got=%0b/%0d/%0b want=1/12/1", reg_write, rd_addr, mc_ready); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_random();
    int errs;
    $display("test_random");
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      pipe_we   = ($urandom_range(0, 2) != 0);
      pipe_rd   = 5'($urandom_range(0, 31));
      pipe_data = $urandom;
      mc_valid  = $urandom_range(0, 1);
      mc_rd     = 5'($urandom_range(0, 31));
      mc_data   = $urandom;
      rs_addr   = 5'($urandom_range(0, 31));
      rt_addr   = 5'($urandom_range(0, 31));
      mc_issue_rd = 5'($urandom_range(0, 31));
      mc_issue  = ($urandom_range(0, 2) == 0);
      if (rst_n && mc_issue && pend[mc_issue_rd] && !(m_xfer() && mc_rd == mc_issue_rd)) mc_issue = 0;
      #2;
      errs = 0;
      if (reg_write !== exp_we()) errs++;
      if (rd_addr !== exp_addr()) errs++;
      if (rd_data !== exp_data()) errs++;
      if (mc_ready !== exp_ready()) errs++;
      if (hazard !== exp_hazard()) errs++;
      if (pipe_hold !== m_hold) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL rand_%0d got we=%0b a=%0d d=%h rdy=%0b hz=%0b hold=%0b want we=%0b a=%0d d=%h rdy=%0b hz=%0b hold=%0b",
                 n, reg_write, rd_addr, rd_data, mc_ready, hazard, pipe_hold,
                 exp_we(), exp_addr(), exp_data(), exp_ready(), exp_hazard(), m_hold);
      end
      tick();
    end
    rst_n = 1;
    set_idle();
    tick();
  endtask

`ifdef RF_WB_ARB_STATS_EN
  task automatic test_stats();
    $display("test_stats");
    set_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    #2;
    total++; if (conflict_cnt !== 16'd0 || hold_cnt !== 16'd0) begin
      bad++; $display("FAIL stats_reset got=%0d/%0d want=0/0", conflict_cnt, hold_cnt); end
    mc_valid = 1; mc_rd = 8; pipe_we = 1; pipe_rd = 5;
    for (int k = 0; k < 3; k++) tick();
    pipe_we = 0;
    #2;
    total++; if (conflict_cnt !== 16'd3 || conflict_cnt !== 16'(m_conf)) begin
      bad++; $display("FAIL stats_conf3 got=%0d want=3", conflict_cnt); end
    tick();
    pipe_we = 1;
    for (int k = 0; k < 70000; k++) tick();
    #2;
    total++; if (conflict_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_conf_sat got=%h want=ffff", conflict_cnt); end
    total++; if (hold_cnt !== 16'(m_holdc)) begin bad++; $display("FAIL stats_hold got=%0d want=%0d", hold_cnt, m_holdc); end
    pipe_we = 0;
    tick();
    set_idle();
    tick();
  endtask
`endif

  initial begin
    foreach (pend[i]) pend[i] = 0;
    m_blocked = 0; m_hold = 0; m_conf = 0; m_holdc = 0;
    test_reset();
    test_priority();
    test_x0_drop();
    test_scoreboard();
    test_starvation();
    test_set_clear_reset();
    test_random();
`ifdef RF_WB_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage and a multi-cycle execution unit (mul/div) that returns results through a valid/ready handshake.
- Keeps a scoreboard of destination registers with multi-cycle results still in flight, and flags read-after-write hazards to decode.
- Enforces a starvation limit that asks the pipeline to hold one cycle so the multi-cycle unit can reach the write port.
- Sits between writeback/MC unit and the register file write inputs (RegWrite/RDaddr/RDdata).

Parameters:
- DATA_W, 32, width of write data.
- STARVE_LIMIT, 4, consecutive blocked MC cycles before pipe_hold_o asserts; legal 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- pipe_we_i  input  1  pipeline writeback write enable.
- pipe_rd_i  input  5  pipeline writeback destination.
- pipe_data_i  input  DATA_W  pipeline writeback data.
- mc_issue_i  input  1  multi-cycle op issued this cycle.
- mc_issue_rd_i  input  5  destination of issued multi-cycle op.
- mc_valid_i  input  1  multi-cycle result valid.
- mc_rd_i  input  5  multi-cycle result destination.
- mc_data_i  input  DATA_W  multi-cycle result data.
- mc_ready_o  output  1  write port free for MC result this cycle.
- rs_addr_i  input  5  decode source register 1.
- rt_addr_i  input  5  decode source register 2.
- hazard_o  output  1  a decode source is pending in scoreboard.
- pipe_hold_o  output  1  request the pipeline to leave the next writeback slot empty.
- RegWrite_o  output  1  register file write enable.
- RDaddr_o  output  5  register file write address.
- RDdata_o  output  DATA_W  register file write data.

Behaviour:
- Reset: synchronous, active-low. Sampled on rising edge of clk; no asynchronous path.
  - At reset: scoreboard pending[31:1] = 0, wait counter = 0, pipe_hold_o = 0.
  - While rst_n = 0: RegWrite_o = 0 and mc_ready_o = 0 (combinationally gated). RDaddr_o = 0, RDdata_o = 0. hazard_o = 0.
- Write port is combinational, zero latency: the selected write appears on RegWrite_o/RDaddr_o/RDdata_o in the same cycle.
- pipe_act = pipe_we_i & (pipe_rd_i != 0). Writes to x0 are dropped and do not occupy the port.
- Pipeline has fixed priority and is never back-pressured.
  - pipe_act = 1: RegWrite_o = 1, RDaddr_o = pipe_rd_i, RDdata_o = pipe_data_i, mc_ready_o = 0.
  - Otherwise: mc_ready_o = 1. MC transfer occurs when mc_valid_i & mc_ready_o.
  - On MC transfer: RegWrite_o = (mc_rd_i != 0), RDaddr_o = mc_rd_i, RDdata_o = mc_data_i. An MC result to x0 completes the handshake with no write.
  - Idle (no pipe_act, no transfer): RegWrite_o = 0, RDaddr_o = 0, RDdata_o = 0.
- Scoreboard:
  - mc_issue_i with rd != 0 sets pending[rd] at the next edge.
  - An MC transfer clears pending[mc_rd_i].
  - Same rd set and cleared in one cycle: set wins (pending stays 1).
  - pending[0] is constant 0.
  - hazard_o = pending[rs_addr_i] | pending[rt_addr_i], combinational from registered state.
  - Registers are not forwarded: the cycle the MC result is written, hazard_o for that register is still 1; it drops the following cycle.
- Starvation state machine, two states:
  - IDLE: wait_cnt counts cycles with mc_valid_i & ~mc_ready_o. When wait_cnt reaches STARVE_LIMIT, go to HOLD.
  - HOLD: pipe_hold_o = 1 (registered). Stay until an MC transfer, then go to IDLE at the next edge with wait_cnt = 0.
  - wait_cnt also clears whenever mc_valid_i = 0 or a transfer occurs.
  - A pipeline write still arriving while in HOLD keeps priority. HOLD persists until a free slot occurs.
- Reset mid-operation: pending flags are lost and HOLD exits. After reset release, an MC result still outstanding is accepted normally; its clear is a no-op.
- Issue to a register already pending is illegal upstream. The block takes no corrective action; a simulation assertion flags it.

Optional Feature:
- Macro: RF_WB_ARB_STATS_EN.
- Defined: adds two outputs.
  - conflict_cnt_o [15:0]: saturating count of cycles with mc_valid_i & pipe_act.
  - hold_cnt_o [15:0]: saturating count of cycles with pipe_hold_o = 1.
  - Both reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Pipe write x5 = 0x1234 and MC valid x7 in the same cycle -> RegWrite_o = 1, RDaddr_o = 5, mc_ready_o = 0. Next cycle, with pipe idle: x7 is written and the handshake completes.
- mc_issue_i rd = 9 -> hazard_o = 1 for rs_addr_i = 9 from the next cycle. MC result x9 written at cycle N -> hazard_o = 0 at cycle N+1.
- Pipe write to x0 while MC valid x3 -> pipe write dropped, mc_ready_o = 1, x3 written the same cycle.
- STARVE_LIMIT = 4, MC valid held while pipe writes nonzero rd every cycle -> pipe_hold_o = 1 after 4 blocked cycles. Pipe idles -> MC writes, and pipe_hold_o = 0 the cycle after.
- Issue rd = 12 and complete rd = 12 in the same cycle -> pending[12] remains 1. rst_n = 0 for one cycle -> pending cleared, RegWrite_o = 0 during reset.
- With RF_WB_ARB_STATS_EN defined: 3 conflict cycles -> conflict_cnt_o = 3. 70000 conflict cycles -> saturates at 0xFFFF.
